bullet_launcher: RTL
====================

# bullet_launcher

Projectile engine on the receiving end of the turret-angle controller. It takes the turret's per-frame bullet motion vector and muzzle position, launches one bullet on a fire-key press, and steps it once per video frame. It retires the bullet on a screen-edge exit, a collision hit, or lifetime expiry, then enforces a cooldown and tracks ammo. The outputs feed the sprite/color mapper and the collision logic.

## Interface
Parameters:
- FIRE_KEY, 8'h2C, keycode that fires (space).
- RELOAD_KEY, 8'h15, keycode that refills ammo ('R').
- X_MAX, 639, largest legal bullet x.
- Y_MAX, 479, largest legal bullet y.
- COOLDOWN_FRAMES, 15, frames between retire and re-arm (0–255).
- MAX_LIFE, 255, flight lifetime in frames (1–255).
- AMMO, 8, rounds after reset/reload (1–15).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low; all state clears immediately on assertion.
- frame_clk  in  1  vsync-rate strobe, asynchronous to Clk.
- keycode  in  8  current USB keycode.
- motion_x, motion_y  in  10 each  two's-complement per-frame step from the turret controller.
- init_pos_x, init_pos_y  in  10 each  muzzle position from the turret controller.
- hit  in  1  one-cycle collision pulse.
- bullet_active  out  1  bullet is in flight.
- bullet_x, bullet_y  out  10 each  current bullet position.
- shot_fired  out  1  one-cycle pulse when a launch occurs.
- ammo_left  out  4  remaining rounds.

## Operation
- States: IDLE, FLIGHT, COOLDOWN.
- Key edges: keycode is registered every cycle. press_fire = (keycode==FIRE_KEY) && (key_q!=FIRE_KEY). press_reload is defined the same way with RELOAD_KEY.
- IDLE with press_fire and ammo_left>0:
  - Go to FLIGHT.
  - Load bullet_x/y from init_pos_x/y.
  - Latch motion_x/y into the velocity registers.
  - Decrement ammo_left, pulse shot_fired, and set the life counter to MAX_LIFE.
- IDLE with press_fire and ammo_left==0: no action.
- IDLE with press_reload: ammo_left=AMMO.
- Key presses in FLIGHT or COOLDOWN are dropped, not queued. Reload outside IDLE is ignored.
- Turret motion changes during FLIGHT have no effect, because velocity stays latched until retire.
- FLIGHT, on each frame tick:
  - Compute nx = bullet_x + vx and ny = bullet_y + vy, mod 2^10.
  - A negative result wraps to a large value, so a single unsigned compare catches both edges.
  - If nx>X_MAX, ny>Y_MAX, or life==1: retire. Positions hold their last legal value.
  - Otherwise update the positions and decrement life.
- Retire behaviour:
  - bullet_active drops.
  - The cooldown counter is set to COOLDOWN_FRAMES.
  - The state goes to COOLDOWN, or straight to IDLE if COOLDOWN_FRAMES==0.
- hit in FLIGHT retires the bullet on that cycle. It has priority over a frame tick in the same cycle, and no position update occurs.
- hit outside FLIGHT is ignored.
- COOLDOWN: the counter decrements on each tick. Reaching 0 returns the state to IDLE.

## Timing
- Reset values: state IDLE, bullet_active 0, bullet_x/y 0, shot_fired 0, ammo_left AMMO, all counters 0, key_q 0, synchronizer 0.
- Frame tick path:
  - frame_clk passes through three flops s1, s2, s3.
  - tick = s2 & ~s3, one Clk cycle wide.
  - Updates happen 2–3 Clk edges after frame_clk rises.
- Launch: the keycode change is sampled at edge N. At edge N+1, bullet_active=1, positions equal init_pos, and shot_fired=1 for exactly one cycle.
- Step: position registers change on the Clk edge where tick=1.
- Retire: bullet_active falls on the same edge the retire condition is evaluated.
- Reset mid-flight: outputs clear asynchronously. The next press_fire after Reset releases launches normally.

## Structure
- Package bullet_pkg holds the state enum, the key constants FIRE_KEY_DEF and RELOAD_KEY_DEF, and the screen limits. These are shared with the turret controller and the mapper.
- One sub-module, frame_tick_sync, contains the 3-flop synchronizer and the rising-edge detector. It is reusable by the other per-frame movers.
- Everything else lives in bullet_launcher as one FSM plus datapath.

## Test plan
- Launch:
  - Stimulus: init_pos=(85,40), motion=(2,0), fire press.
  - Response: shot_fired one cycle; bullet at (85,40); after 3 ticks at (91,40); ammo_left=7.
- Upward exit:
  - Stimulus: init=(38,42), motion=(0,-2).
  - Response: the 21st tick would give y=0; the 22nd tick wraps y to 1022 and retires the bullet with bullet_y holding 0; COOLDOWN lasts 15 ticks; then IDLE.
- Hit priority:
  - Stimulus: hit and tick in the same cycle during FLIGHT.
  - Response: no position step; bullet_active=0 next edge.
- Ammo and reload:
  - Stimulus: 8 fire/retire cycles with COOLDOWN_FRAMES=0; a 9th press; then a reload press; then fire.
  - Response: the 9th press does nothing and ammo_left=0; after reload ammo_left=8; the following fire launches.
- Held or blocked keys:
  - Stimulus: fire held for 100 frames; fire pressed during FLIGHT; motion changed mid-flight.
  - Response: one launch only, press ignored, trajectory unchanged.
- Async reset:
  - Stimulus: assert Reset mid-flight between Clk edges.
  - Response: bullet_active=0, position=(0,0), ammo_left=8 immediately.

Source files
------------

// File: rtl/bullet_launcher_pkg.sv
// Shared definitions for the bullet launcher, turret controller and sprite mapper.
// Holds the FSM state encoding, default keycodes and screen limits.
package bullet_pkg;

    localparam int unsigned POS_W  = 10;
    localparam int unsigned KEY_W  = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned AMMO_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLIGHT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } bullet_state_e;

    localparam logic [KEY_W-1:0] FIRE_KEY_DEF   = 8'h2C;
    localparam logic [KEY_W-1:0] RELOAD_KEY_DEF = 8'h15;

    localparam logic [POS_W-1:0] X_MAX_DEF = 10'd639;
    localparam logic [POS_W-1:0] Y_MAX_DEF = 10'd479;

    // Negative steps wrap to large unsigned values, so one compare per axis covers both edges.
    function automatic logic off_screen(
        input logic [POS_W-1:0] nx,
        input logic [POS_W-1:0] ny,
        input logic [POS_W-1:0] x_max,
        input logic [POS_W-1:0] y_max
    );
        return (nx > x_max) || (ny > y_max);
    endfunction

endpackage

// File: rtl/bullet_launcher_if.sv
// Keyboard, turret and collision inputs plus bullet state outputs of the launcher.
// master = driver side (turret/keyboard/collision), slave = the launcher itself.
interface bullet_launcher_if;
    import bullet_pkg::*;

    logic [KEY_W-1:0]  keycode;
    logic [POS_W-1:0]  motion_x;
    logic [POS_W-1:0]  motion_y;
    logic [POS_W-1:0]  init_pos_x;
    logic [POS_W-1:0]  init_pos_y;
    logic              hit;
    logic              bullet_active;
    logic [POS_W-1:0]  bullet_x;
    logic [POS_W-1:0]  bullet_y;
    logic              shot_fired;
    logic [AMMO_W-1:0] ammo_left;

    modport master (
        output keycode, motion_x, motion_y, init_pos_x, init_pos_y, hit,
        input  bullet_active, bullet_x, bullet_y, shot_fired, ammo_left
    );

    modport slave (
        input  keycode, motion_x, motion_y, init_pos_x, init_pos_y, hit,
        output bullet_active, bullet_x, bullet_y, shot_fired, ammo_left
    );

endinterface

// File: rtl/bullet_launcher_frame_tick_sync.sv
// Brings the asynchronous vsync strobe into clk_i and emits a one-cycle tick on its rise.
// Reusable by any per-frame mover.
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_clk_i,
    output logic tick_o
);

    // sync_q[0..2] are the s1/s2/s3 stages; s1 is the metastability catcher.
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk_i};
        end
    end

    assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bullet_launcher.sv
// Single-bullet projectile engine: launches on a fire-key press, steps once per frame,
// retires on edge exit / hit / lifetime expiry, then cools down before re-arming.
module bullet_launcher
    import bullet_pkg::*;
#(
    parameter logic [KEY_W-1:0] FIRE_KEY        = FIRE_KEY_DEF,
    parameter logic [KEY_W-1:0] RELOAD_KEY      = RELOAD_KEY_DEF,
    parameter logic [POS_W-1:0] X_MAX           = X_MAX_DEF,
    parameter logic [POS_W-1:0] Y_MAX           = Y_MAX_DEF,
    parameter int unsigned      COOLDOWN_FRAMES = 15,
    parameter int unsigned      MAX_LIFE        = 255,
    parameter int unsigned      AMMO            = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             frame_clk_i,
    bullet_launcher_if.slave bus
);

    localparam logic [CNT_W-1:0]  COOL_INIT = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0]  LIFE_INIT = CNT_W'(MAX_LIFE);
    localparam logic [AMMO_W-1:0] AMMO_INIT = AMMO_W'(AMMO);

    bullet_state_e     state_q, state_d;
    logic [KEY_W-1:0]  key_q;
    logic [POS_W-1:0]  bx_q, bx_d, by_q, by_d;
    logic [POS_W-1:0]  vx_q, vx_d, vy_q, vy_d;
    logic [CNT_W-1:0]  life_q, life_d;
    logic [CNT_W-1:0]  cool_q, cool_d;
    logic [AMMO_W-1:0] ammo_q, ammo_d;
    logic              shot_q, shot_d;

    logic              tick;
    logic              press_fire, press_reload;
    logic              launch, retire, step, cool_done, oob;
    logic [POS_W-1:0]  nx, ny;

    frame_tick_sync u_frame_tick_sync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .frame_clk_i (frame_clk_i),
        .tick_o      (tick)
    );

    assign press_fire   = (bus.keycode == FIRE_KEY)   && (key_q != FIRE_KEY);
    assign press_reload = (bus.keycode == RELOAD_KEY) && (key_q != RELOAD_KEY);

    assign nx  = bx_q + vx_q;
    assign ny  = by_q + vy_q;
    assign oob = off_screen(nx, ny, X_MAX, Y_MAX);

    // A hit wins over a same-cycle tick, so the position never steps on a hit.
    assign launch    = (state_q == ST_IDLE) && press_fire && (ammo_q != '0);
    assign retire    = (state_q == ST_FLIGHT) &&
                       (bus.hit || (tick && (oob || (life_q == CNT_W'(1)))));
    assign step      = (state_q == ST_FLIGHT) && !bus.hit && tick &&
                       !oob && (life_q != CNT_W'(1));
    assign cool_done = (state_q == ST_COOLDOWN) && tick && (cool_q <= CNT_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_FLIGHT;
                end
            end
            ST_FLIGHT: begin
                if (retire) begin
                    state_d = (COOL_INIT == '0) ? ST_IDLE : ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (cool_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.bullet_active = (state_q == ST_FLIGHT);
        bus.bullet_x      = bx_q;
        bus.bullet_y      = by_q;
        bus.shot_fired    = shot_q;
        bus.ammo_left     = ammo_q;
    end

    // Datapath next-state: velocity is latched only at launch, so turret motion mid-flight is ignored.
    always_comb begin
        bx_d   = bx_q;
        by_d   = by_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        life_d = life_q;
        cool_d = cool_q;
        ammo_d = ammo_q;
        shot_d = 1'b0;

        if (launch) begin
            bx_d   = bus.init_pos_x;
            by_d   = bus.init_pos_y;
            vx_d   = bus.motion_x;
            vy_d   = bus.motion_y;
            life_d = LIFE_INIT;
            ammo_d = ammo_q - AMMO_W'(1);
            shot_d = 1'b1;
        end

        if (step) begin
            bx_d   = nx;
            by_d   = ny;
            life_d = life_q - CNT_W'(1);
        end

        if (retire) begin
            cool_d = COOL_INIT;
        end

        if ((state_q == ST_COOLDOWN) && tick && (cool_q != '0)) begin
            cool_d = cool_q - CNT_W'(1);
        end

        if ((state_q == ST_IDLE) && press_reload) begin
            ammo_d = AMMO_INIT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q  <= '0;
            bx_q   <= '0;
            by_q   <= '0;
            vx_q   <= '0;
            vy_q   <= '0;
            life_q <= '0;
            cool_q <= '0;
            ammo_q <= AMMO_INIT;
            shot_q <= 1'b0;
        end else begin
            key_q  <= bus.keycode;
            bx_q   <= bx_d;
            by_q   <= by_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            life_q <= life_d;
            cool_q <= cool_d;
            ammo_q <= ammo_d;
            shot_q <= shot_d;
        end
    end

endmodule
